// File: rtl/pairing_pkg.sv
// Shared constants and state encoding for the pairing core host bridge.
package pairing_pkg;

    // Default field extension degree of each F(3^m) element.
    localparam int unsigned M = 97;

    // Word counts of the 32-bit host streams.
    localparam int unsigned LOAD_WORDS        = 28;
    localparam int unsigned UNLOAD_WORDS      = 37;
    localparam int unsigned WORDS_PER_OPERAND = 7;

    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StWait,
        StUnload
    } state_t;

endpackage

// File: rtl/pairing_out_serializer.sv
// Result register plus 32-bit word serializer for the pairing core output.
// Words go out LSW first; the result is zero-padded up to UNLOAD_WORDS words.
module pairing_out_serializer
    import pairing_pkg::*;
#(
    parameter int unsigned M = pairing_pkg::M
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [12*M-1:0]   result_in,
    input  logic              active,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              done
);

    localparam int unsigned PadW = 32 * UNLOAD_WORDS;

    logic [12*M-1:0] result_q;
    logic [5:0]      cnt_q;
    logic [PadW-1:0] padded;
    logic            fire;

    assign padded    = PadW'(result_q);
    assign out_valid = active;
    assign out_data  = padded[32*cnt_q +: 32];
    assign out_last  = active && (cnt_q == 6'(UNLOAD_WORDS - 1));
    assign fire      = active && out_ready;
    assign done      = fire && out_last;

    // Result register, loaded once when the core reports done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (capture) begin
            result_q <= result_in;
        end
    end

    // Word index; returns to 0 when the last word is taken, never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (fire) begin
            cnt_q <= out_last ? 6'd0 : cnt_q + 6'd1;
        end
    end

endmodule

// File: rtl/pairing_host_bridge.sv
// Host bridge for a Tate pairing core: loads x1,y1,x2,y2 from a 32-bit word
// stream, pulses the core through reset/start, waits for done and streams
// the 12*M-bit result back out.
// Optional build macro PAIRING_TIMEOUT_EN adds a WAIT-state watchdog with a
// sticky err flag; without it WAIT is unbounded and err is tied low.
module pairing_host_bridge
    import pairing_pkg::*;
#(
    parameter int unsigned M              = pairing_pkg::M,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic [2*M-1:0]    x1,
    output logic [2*M-1:0]    y1,
    output logic [2*M-1:0]    x2,
    output logic [2*M-1:0]    y2,
    output logic              core_reset,
    input  logic              core_done,
    input  logic [12*M-1:0]   core_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam int unsigned OpW    = 2 * M;
    localparam int unsigned PadOpW = 32 * WORDS_PER_OPERAND;
    localparam int unsigned SW     = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [4:0]        load_cnt_q, load_cnt_d;
    logic [SW-1:0]     start_cnt_q, start_cnt_d;
    logic [OpW-1:0]    x1_q, y1_q, x2_q, y2_q;
    logic [OpW-1:0]    x1_d, y1_d, x2_d, y2_d;
    logic [PadOpW-1:0] op_wide;
    logic [2:0]        op_sel, word_sel;
    logic              accept, capture, unload_done, timeout;

    assign in_ready   = (state_q == StLoad);
    assign accept     = in_valid && in_ready;
    assign core_reset = (state_q != StWait);
    assign busy       = (state_q != StLoad);
    assign op_sel     = 3'(load_cnt_q / 5'd7);
    assign word_sel   = 3'(load_cnt_q % 5'd7);
    assign x1 = x1_q;
    assign y1 = y1_q;
    assign x2 = x2_q;
    assign y2 = y2_q;

    // Merge the accepted word into the selected operand; bits above OpW drop.
    always_comb begin
        x1_d = x1_q;
        y1_d = y1_q;
        x2_d = x2_q;
        y2_d = y2_q;
        case (op_sel)
            3'd0:    op_wide = PadOpW'(x1_q);
            3'd1:    op_wide = PadOpW'(y1_q);
            3'd2:    op_wide = PadOpW'(x2_q);
            default: op_wide = PadOpW'(y2_q);
        endcase
        op_wide[32*word_sel +: 32] = in_data;
        if (accept) begin
            case (op_sel)
                3'd0:    x1_d = op_wide[OpW-1:0];
                3'd1:    y1_d = op_wide[OpW-1:0];
                3'd2:    x2_d = op_wide[OpW-1:0];
                default: y2_d = op_wide[OpW-1:0];
            endcase
        end
    end

    // Next-state logic for the LOAD/START/WAIT/UNLOAD sequence.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        start_cnt_d = start_cnt_q;
        capture     = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (load_cnt_q == 5'(LOAD_WORDS - 1)) begin
                        load_cnt_d = '0;
                        state_d    = StStart;
                    end else begin
                        load_cnt_d = load_cnt_q + 5'd1;
                    end
                end
            end
            StStart: begin
                if (start_cnt_q == SW'(START_CYCLES - 1)) begin
                    start_cnt_d = '0;
                    state_d     = StWait;
                end else begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end
            end
            StWait: begin
                if (core_done) begin
                    capture = 1'b1;
                    state_d = StUnload;
                end else if (timeout) begin
                    state_d = StLoad;
                end
            end
            StUnload: begin
                if (unload_done) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // State, counters and operand registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StLoad;
            load_cnt_q  <= '0;
            start_cnt_q <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            start_cnt_q <= start_cnt_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            x2_q        <= x2_d;
            y2_q        <= y2_d;
        end
    end

`ifdef PAIRING_TIMEOUT_EN
    logic [19:0] wait_cnt_q;
    logic        err_q;

    // core_done on the final cycle still wins over the watchdog.
    assign timeout = (state_q == StWait) && !core_done &&
                     (wait_cnt_q == 20'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    // Cycles spent in WAIT; cleared in every other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == StWait) begin
            wait_cnt_q <= wait_cnt_q + 20'd1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted operand word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (accept) begin
            err_q <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    pairing_out_serializer #(
        .M (M)
    ) u_out_serializer (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .result_in (core_out),
        .active    (state_q == StUnload),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (unload_done)
    );

endmodule
